// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode and optional immediate bytes from program memory
// over a req/ack port and hands them to the core with a valid/ready handshake.
module instr_fetch #(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        instr,
   input  logic              need_imm,
   output logic [7:0]        imm,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [2:0] {
      StIdle,
      StOp,
      StDec,
      StImm,
      StIssue
   } state_t;

   state_t state;

   // The address is always the PC; it only changes on an ack or an issue, so it is stable
   // for the whole life of a request.
   assign mem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         pc          <= RESET_PC;
         instr       <= 8'h00;
         imm         <= 8'h00;
         instr_valid <= 1'b0;
         mem_req     <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               state   <= StOp;
               mem_req <= 1'b1;
            end
            StOp: begin
               if (mem_ack) begin
                  instr   <= mem_rdata;
                  pc      <= pc + ADDR_W'(1);
                  state   <= StDec;
                  mem_req <= 1'b0;
               end
            end
            StDec: begin
               // instr is registered here, so the decoder output has settled
               if (need_imm) begin
                  state   <= StImm;
                  mem_req <= 1'b1;
               end else begin
                  imm         <= 8'h00;
                  state       <= StIssue;
                  instr_valid <= 1'b1;
               end
            end
            StImm: begin
               if (mem_ack) begin
                  imm         <= mem_rdata;
                  pc          <= pc + ADDR_W'(1);
                  state       <= StIssue;
                  mem_req     <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            StIssue: begin
               if (instr_ready) begin
                  // Target replaces the already-advanced PC; no further increment.
                  pc          <= branch_taken ? branch_target : pc;
                  state       <= StOp;
                  instr_valid <= 1'b0;
                  mem_req     <= 1'b1;
               end
            end
            default: begin
               state       <= StIdle;
               instr_valid <= 1'b0;
               mem_req     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized memory latency, core backpressure
// and branches, checked every cycle against a transaction-level model of the fetch stream.
module tb_instr_fetch;

   localparam logic [7:0] RESET_PC = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] instr;
   logic       need_imm;
   logic [7:0] imm;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic [7:0] pc;

   instr_fetch #(
      .ADDR_W  (8),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .need_imm     (need_imm),
      .imm          (imm),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (pc)
   );

   // Toy decoder: opcodes with the top bit set carry an immediate byte.
   assign need_imm = instr[7];

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model / compare process ----------------
   logic [7:0] m_fetch;     // address of the current instruction's opcode
   int         m_idx;       // bytes of the current instruction already delivered
   int         rel_cnt;
   bit         prev_hs, prev_req, prev_valid, op_zw;
   int         t_op;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_req", mem_req, 0);
         chk("rst_valid", instr_valid, 0);
         chk("rst_pc", pc, RESET_PC);
         chk("rst_instr", instr, 0);
         chk("rst_imm", imm, 0);
         m_fetch = RESET_PC;
         m_idx = 0;
         rel_cnt = 0;
         prev_hs = 0;
         prev_req = 0;
         prev_valid = 0;
         op_zw = 0;
      end else begin
         if (rel_cnt == 0) chk("idle_no_req", mem_req, 0);
         if (rel_cnt == 1) chk("first_req", mem_req, 1);
         if (rel_cnt < 2) rel_cnt++;
         if (prev_hs) chk("issue_to_req", mem_req, 1);
         if (mem_req) begin
            chk("req_addr", mem_addr, 8'(m_fetch + 8'(m_idx)));
            chk("req_no_valid", instr_valid, 0);
            if (!prev_req && m_idx == 0) begin
               t_op = cyc;
               op_zw = mem_ack;
            end
            if (mem_ack) m_idx++;
         end
         if (instr_valid) begin
            automatic logic [7:0] e_op  = mem[m_fetch];
            automatic bit         e_ni  = e_op[7];
            automatic logic [7:0] e_imm = e_ni ? mem[8'(m_fetch + 8'd1)] : 8'h00;
            automatic logic [7:0] e_pc  = 8'(m_fetch + (e_ni ? 8'd2 : 8'd1));
            chk("bytes_fetched", m_idx, e_ni ? 2 : 1);
            chk("instr", instr, e_op);
            chk("imm", imm, e_imm);
            chk("pc_at_issue", pc, e_pc);
            if (!prev_valid && !e_ni && op_zw) chk("latency_noimm", cyc - t_op, 2);
            if (instr_ready) begin
               m_fetch = branch_taken ? branch_target : e_pc;
               m_idx = 0;
            end
         end
         prev_hs = instr_valid && instr_ready;
         prev_req = mem_req;
         prev_valid = instr_valid;
      end
   end

   // ---------------- stimulus driver ----------------
   int  delay_mode  = 0;   // <0: random 0..3, otherwise fixed wait cycles
   int  ready_mode  = 0;   // 0 low, 1 high, 2 random
   int  branch_mode = 0;   // 0 never, 1 forced target, 2 random
   logic [7:0] force_tgt = 8'h00;
   int  wait_cnt = 0;
   bit  req_started = 0;

   function automatic int pick_delay();
      return (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (rst) req_started = 0;
      else if (mem_req) begin
         if (!req_started) begin
            req_started = 1;
            wait_cnt = pick_delay();
         end
         if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            req_started = 0;
         end else wait_cnt--;
      end
      instr_ready = (ready_mode == 1) ? 1'b1 :
                    (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      branch_taken = (branch_mode == 1) ? 1'b1 :
                     (branch_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      branch_target = (branch_mode == 1) ? force_tgt : 8'($urandom);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 100) begin
         step();
         n++;
      end
      if (!instr_valid) chk({name, "_timeout"}, instr_valid, 1);
   endtask

   // Accept the presented instruction; afterwards the DUT is in its first fetch cycle.
   task automatic issue(input bit br, input logic [7:0] tgt);
      ready_mode = 1;
      branch_mode = br ? 1 : 0;
      force_tgt = tgt;
      step();
      ready_mode = 0;
      branch_mode = 0;
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom) & 8'h7F;
      mem[8'h00] = 8'h10;
      mem[8'h01] = 8'h11;
      mem[8'h02] = 8'hC0;
      mem[8'h03] = 8'h2A;
      mem[8'h40] = 8'h05;
      mem[8'hFF] = 8'h9A;

      step();
      step();
      chk("lit_rst_pc", pc, 8'h00);
      chk("lit_rst_instr", instr, 8'h00);
      rst = 1'b0;
      chk("lit_idle_req", mem_req, 0);
      step();
      chk("lit_first_req", mem_req, 1);
      chk("lit_first_addr", mem_addr, 8'h00);

      wait_valid("op10");
      chk("lit_op10_instr", instr, 8'h10);
      chk("lit_op10_imm", imm, 8'h00);
      chk("lit_op10_pc", pc, 8'h01);
      issue(0, 8'h00);
      chk("lit_next_addr01", mem_addr, 8'h01);

      wait_valid("op11");
      issue(0, 8'h00);
      wait_valid("opC0");
      chk("lit_opC0_instr", instr, 8'hC0);
      chk("lit_opC0_imm", imm, 8'h2A);
      chk("lit_opC0_pc", pc, 8'h04);
      issue(1, 8'h40);
      chk("lit_branch_addr", mem_addr, 8'h40);

      wait_valid("op05");
      chk("lit_op05_pc", pc, 8'h41);
      delay_mode = 3;
      issue(1, 8'hFF);
      chk("lit_wrap_op_addr", mem_addr, 8'hFF);

      wait_valid("op9A");
      chk("lit_wrap_instr", instr, 8'h9A);
      chk("lit_wrap_imm", imm, 8'h10);
      chk("lit_wrap_pc", pc, 8'h01);
      for (int i = 0; i < 5; i++) step();
      chk("lit_hold_instr", instr, 8'h9A);
      chk("lit_hold_imm", imm, 8'h10);
      chk("lit_hold_pc", pc, 8'h01);
      chk("lit_hold_req", mem_req, 0);
      chk("lit_hold_valid", instr_valid, 1);
      issue(0, 8'h00);

      // Opcode request is waiting and not yet acked, so refreshing memory is safe here.
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      delay_mode = -1;
      ready_mode = 2;
      branch_mode = 2;
      for (int i = 0; i < 3000; i++) step();

      // Reset in the middle of an immediate fetch, then a stale ack right after release.
      ready_mode = 1;
      branch_mode = 0;
      delay_mode = 2;
      begin
         int n = 0;
         while (!(mem_req && m_idx == 1) && n < 500) begin
            step();
            n++;
         end
         chk("find_imm_fetch", mem_req && m_idx == 1, 1);
      end
      mem[RESET_PC] = 8'h33;
      rst = 1'b1;
      #1;
      chk("lit_midimm_rst_pc", pc, RESET_PC);
      chk("lit_midimm_rst_req", mem_req, 0);
      step();
      step();
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 8'hEE;
      chk("lit_rel_idle_req", mem_req, 0);
      step();
      wait_valid("after_rst");
      chk("lit_after_rst_instr", instr, 8'h33);
      chk("lit_after_rst_pc", pc, 8'(RESET_PC + 8'd1));
      issue(0, 8'h00);
      for (int i = 0; i < 10; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
